field_packetizer: RTL

// - Upstream feeder for the deinterlacer: turns a raw, non-stallable interlaced pixel stream into Avalon-ST video packets.
// - Emits one control packet plus one video packet per field.
// - A small FIFO absorbs pixels arriving while packet headers are sent and while the sink is back-pressuring.

---
 rtl/field_packetizer_pkg.sv | 45 ++++
 rtl/field_packetizer_sync_fifo.sv | 60 ++++++
 rtl/field_packetizer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/field_packetizer_pkg.sv
// Shared types and constants for the field packetizer.
// Holds the FSM state encoding, the Avalon-ST video packet type nibbles,
// the interlace nibbles, and the helper that builds control packet beats.
package field_packetizer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CTRL = 2'd1,
      VHDR = 2'd2,
      VID  = 2'd3
   } state_t;

   localparam logic [3:0] PKT_CTRL  = 4'hF;
   localparam logic [3:0] PKT_VIDEO = 4'h0;
   localparam logic [3:0] IL_F0     = 4'b1000;
   localparam logic [3:0] IL_F1     = 4'b1100;

   // Index of the final beat of the control packet
   localparam logic [3:0] CTRL_LAST = 4'd9;

   // Nibble carried by control packet beat idx. Width and height are sent
   // most-significant nibble first; the last beat is the interlace nibble.
   function automatic logic [3:0] ctrl_nibble(input logic [3:0]  idx,
                                              input logic [15:0] width,
                                              input logic [15:0] height,
                                              input logic        field);
      logic [3:0] nib;
      nib = 4'h0;
      case (idx)
         4'd0:    nib = PKT_CTRL;
         4'd1:    nib = width[15:12];
         4'd2:    nib = width[11:8];
         4'd3:    nib = width[7:4];
         4'd4:    nib = width[3:0];
         4'd5:    nib = height[15:12];
         4'd6:    nib = height[11:8];
         4'd7:    nib = height[7:4];
         4'd8:    nib = height[3:0];
         4'd9:    nib = field ? IL_F1 : IL_F0;
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/field_packetizer_sync_fifo.sv
// Single-clock show-ahead FIFO used to buffer the non-stallable pixel stream.
// q always presents the oldest entry while not empty. A write while full is
// refused unless a read happens in the same cycle, in which case both proceed.
module sync_fifo
   import field_packetizer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_req,
   input  logic                  rd_req,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q;
   logic [AW:0]           rd_ptr_q;
   logic                  wr_en;
   logic                  rd_en;

   // Pointers carry one extra wrap bit to tell full from empty
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      rd_en = rd_req && !empty;
      wr_en = wr_req && (!full || rd_en);
      q     = mem_q[rd_ptr_q[AW-1:0]];
   end

   // Storage array; contents are don't-care while empty, so no reset
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data;
      end
   end

   // Read and write pointer advance
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/field_packetizer.sv
// Turns a raw interlaced pixel stream into Avalon-ST video packets: one
// control packet followed by one video packet per field. Pixels that arrive
// during headers or sink back-pressure are held in a small FIFO.
// Optional build macro FIELD_PACKETIZER_STATS_EN adds a field_count output
// counting accepted video end-of-packet beats.
//
// state | meaning
// IDLE  | waiting for pix_sof; FIFO writes suppressed until it arrives
// CTRL  | sending the 10-beat control packet (type, width, height, interlace)
// VHDR  | sending the single video packet type beat
// VID   | streaming FIFO pixels; leaves once the EOP beat is accepted
module field_packetizer
   import field_packetizer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] pix_data,
   input  logic                  pix_valid,
   input  logic                  pix_sof,
   input  logic                  pix_field,
   output logic [DATA_WIDTH-1:0] dout_data,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  dout_startofpacket,
   output logic                  dout_endofpacket,
`ifdef FIELD_PACKETIZER_STATS_EN
   output logic [15:0]           field_count,
`endif
   output logic                  overflow,
   output logic                  sync_err
);

   localparam int          NPIX     = WIDTH * HEIGHT / 2;
   localparam int          PIX_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
   localparam logic [15:0] WIDTH16  = 16'(WIDTH);
   localparam logic [15:0] FIELD_H16 = 16'(HEIGHT / 2);

   state_t                state_q;
   logic [3:0]            nib_cnt_q;
   logic [PIX_W-1:0]      pix_cnt_q;
   logic                  field_q;
   logic [DATA_WIDTH-1:0] dout_data_q;
   logic                  dout_valid_q;
   logic                  dout_sop_q;
   logic                  dout_eop_q;
   logic                  overflow_q;
   logic                  sync_err_q;

   logic                  load_ok;
   logic                  eop_held;
   logic                  fifo_wr;
   logic                  fifo_rd;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_q;

   // Output register load permission, FIFO write/read strobes
   always_comb begin
      load_ok  = !dout_valid_q || dout_ready;
      eop_held = dout_valid_q && dout_eop_q;
      fifo_wr  = pix_valid && ((state_q != IDLE) || pix_sof);
      fifo_rd  = (state_q == VID) && !eop_held && load_ok && !fifo_empty;
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .wr_req (fifo_wr),
      .rd_req (fifo_rd),
      .data   (pix_data),
      .q      (fifo_q),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Packet sequencer with registered Avalon-ST outputs and sticky flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         nib_cnt_q    <= '0;
         pix_cnt_q    <= '0;
         field_q      <= 1'b0;
         dout_data_q  <= '0;
         dout_valid_q <= 1'b0;
         dout_sop_q   <= 1'b0;
         dout_eop_q   <= 1'b0;
         overflow_q   <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         if (fifo_wr && fifo_full && !fifo_rd) begin
            overflow_q <= 1'b1;
         end
         // A stray SOF is just data; only the pixel counter ends a packet
         if (pix_valid && pix_sof && (state_q != IDLE)) begin
            sync_err_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (pix_valid && pix_sof) begin
                  field_q   <= pix_field;
                  nib_cnt_q <= '0;
                  state_q   <= CTRL;
               end
            end

            CTRL: begin
               if (load_ok) begin
                  dout_data_q  <= DATA_WIDTH'(ctrl_nibble(nib_cnt_q, WIDTH16,
                                                          FIELD_H16, field_q));
                  dout_valid_q <= 1'b1;
                  dout_sop_q   <= (nib_cnt_q == 4'd0);
                  dout_eop_q   <= (nib_cnt_q == CTRL_LAST);
                  if (nib_cnt_q == CTRL_LAST) begin
                     state_q <= VHDR;
                  end else begin
                     nib_cnt_q <= nib_cnt_q + 4'd1;
                  end
               end
            end

            VHDR: begin
               if (load_ok) begin
                  dout_data_q  <= DATA_WIDTH'(PKT_VIDEO);
                  dout_valid_q <= 1'b1;
                  dout_sop_q   <= 1'b1;
                  dout_eop_q   <= 1'b0;
                  pix_cnt_q    <= '0;
                  state_q      <= VID;
               end
            end

            VID: begin
               if (eop_held) begin
                  if (dout_ready) begin
                     dout_valid_q <= 1'b0;
                     dout_eop_q   <= 1'b0;
                     state_q      <= IDLE;
                  end
               end else if (load_ok) begin
                  if (!fifo_empty) begin
                     dout_data_q  <= fifo_q;
                     dout_valid_q <= 1'b1;
                     dout_sop_q   <= 1'b0;
                     dout_eop_q   <= (pix_cnt_q == PIX_LAST);
                     pix_cnt_q    <= (pix_cnt_q == PIX_LAST) ? '0
                                                             : pix_cnt_q + PIX_W'(1);
                  end else begin
                     // Bubble: nothing buffered, so drop valid rather than repeat
                     dout_valid_q <= 1'b0;
                     dout_sop_q   <= 1'b0;
                     dout_eop_q   <= 1'b0;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef FIELD_PACKETIZER_STATS_EN
   logic [15:0] field_count_q;

   // Count video end-of-packet beats as they are accepted; wraps naturally
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         field_count_q <= '0;
      end else if ((state_q == VID) && eop_held && dout_ready) begin
         field_count_q <= field_count_q + 16'd1;
      end
   end

   assign field_count = field_count_q;
`endif

   assign dout_data          = dout_data_q;
   assign dout_valid         = dout_valid_q;
   assign dout_startofpacket = dout_sop_q;
   assign dout_endofpacket   = dout_eop_q;
   assign overflow           = overflow_q;
   assign sync_err           = sync_err_q;

endmodule
